// File: rtl/bpsk_symbol_slicer.sv
// Integrate-and-dump BPSK hard slicer for de-rotated I/Q samples.
// Decided bits are packed MSB-first into bytes on an AXI-Stream master.
module bpsk_symbol_slicer #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int SAMPLES_PER_SYMBOL     = 8,
  parameter int ACC_WIDTH              = 24
) (
  input  logic                              s00_axis_aclk,
  input  logic                              s00_axis_aresetn,
  input  logic                              s00_axis_tvalid,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
  input  logic [3:0]                        s00_axis_tstrb,
  input  logic                              s00_axis_tlast,
  output logic                              s00_axis_tready,
  input  logic                              m00_axis_tready,
  output logic                              m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
  output logic [3:0]                        m00_axis_tstrb,
  output logic                              m00_axis_tlast
);

  localparam int CW = (SAMPLES_PER_SYMBOL > 1) ?
                      $clog2(SAMPLES_PER_SYMBOL) : 1;

  if (ACC_WIDTH < 16 + $clog2(SAMPLES_PER_SYMBOL)) begin : g_acc_chk
    $error("ACC_WIDTH too small for SAMPLES_PER_SYMBOL");
  end
  if (SAMPLES_PER_SYMBOL < 1 || SAMPLES_PER_SYMBOL > 256) begin : g_sps_chk
    $error("SAMPLES_PER_SYMBOL out of range 1..256");
  end
  if (C_S00_AXIS_TDATA_WIDTH != 32 || C_M00_AXIS_TDATA_WIDTH < 8) begin : g_w_chk
    $error("unsupported AXIS data width");
  end

  logic [ACC_WIDTH-1:0] acc_q, acc_d, sum;
  logic [CW-1:0]        samp_cnt_q, samp_cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic                 m_valid_q, m_valid_d;
  logic [7:0]           m_data_q, m_data_d;
  logic                 m_last_q, m_last_d;

  logic       accept, sym_end, emit, dec_bit;
  logic [7:0] shifted, byte_v;
  logic       unused_ok;

  assign unused_ok = ^{s00_axis_tstrb,
                       s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:16]};

  assign s00_axis_tready = !m_valid_q || m00_axis_tready;
  assign accept  = s00_axis_tvalid && s00_axis_tready;
  assign sum     = acc_q + {{(ACC_WIDTH-16){s00_axis_tdata[15]}},
                            s00_axis_tdata[15:0]};
  assign dec_bit = ~sum[ACC_WIDTH-1];
  assign sym_end = accept &&
                   (samp_cnt_q == CW'(SAMPLES_PER_SYMBOL - 1) ||
                    s00_axis_tlast);
  assign emit    = sym_end && (bit_cnt_q == 3'd7 || s00_axis_tlast);
  assign shifted = {shift_q[6:0], dec_bit};
  // A short final byte is left-aligned so the first bit stays in the MSB
  assign byte_v  = shifted << (3'd7 - bit_cnt_q);

  always_comb begin
    acc_d      = acc_q;
    samp_cnt_d = samp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;
    if (accept) begin
      if (sym_end) begin
        acc_d      = '0;
        samp_cnt_d = '0;
        if (emit) begin
          bit_cnt_d = '0;
          shift_d   = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          shift_d   = shifted;
        end
      end else begin
        acc_d      = sum;
        samp_cnt_d = samp_cnt_q + CW'(1);
      end
    end
    if (emit) begin
      m_valid_d = 1'b1;
      m_data_d  = byte_v;
      m_last_d  = s00_axis_tlast;
    end else if (m00_axis_tready) begin
      m_valid_d = 1'b0;
      m_data_d  = '0;
      m_last_d  = 1'b0;
    end
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      acc_q      <= '0;
      samp_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      samp_cnt_q <= samp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
    end
  end

  assign m00_axis_tvalid = m_valid_q;
  assign m00_axis_tdata  = {{(C_M00_AXIS_TDATA_WIDTH-8){1'b0}}, m_data_q};
  assign m00_axis_tstrb  = m_valid_q ? 4'b0001 : 4'b0000;
  assign m00_axis_tlast  = m_last_q;

endmodule
